// File: rtl/dispatch_pkg.sv
// Shared state encoding and default sizing for the thread-block dispatcher.
package dispatch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        RUN,
        DONE,
        ABORT
    } state_t;

    localparam int DEF_NUM_CORES  = 4;
    localparam int DEF_TC_WIDTH   = 16;
    localparam int DEF_MAX_TPB    = 8;
    localparam int DEF_CYC_WIDTH  = 32;
    localparam int DEF_TPB_LOG2_W = $clog2(DEF_MAX_TPB) + 1;
    localparam int DEF_SIZE_W     = DEF_TPB_LOG2_W;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set bit of eligible at or above ptr, wrapping.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  eligible,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] index
);

    // Scan from the far end so the candidate closest to ptr is written last and wins.
    always_comb begin
        found = 1'b0;
        index = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (eligible[(int'(ptr) + k) % N]) begin
                found = 1'b1;
                index = IW'((int'(ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/block_dispatcher.sv
// Thread-block dispatcher: splits a kernel launch into power-of-two blocks and
// issues at most one per cycle round-robin to idle, enabled cores.
module block_dispatcher
    import dispatch_pkg::*;
#(
    parameter int NUM_CORES = DEF_NUM_CORES,
    parameter int TC_WIDTH  = DEF_TC_WIDTH,
    parameter int MAX_TPB   = DEF_MAX_TPB,
    parameter int CYC_WIDTH = DEF_CYC_WIDTH
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    launch_valid,
    output logic                                    launch_ready,
    input  logic [TC_WIDTH-1:0]                     launch_thread_count,
    input  logic [$clog2(MAX_TPB):0]                launch_tpb_log2,
    input  logic [NUM_CORES-1:0]                    core_enable_mask,
    input  logic                                    abort,
    input  logic [NUM_CORES-1:0]                    core_done,
    output logic [NUM_CORES-1:0]                    core_start,
    output logic [NUM_CORES-1:0]                    core_reset,
    output logic [NUM_CORES-1:0][TC_WIDTH-1:0]      core_block_id,
    output logic [NUM_CORES-1:0][$clog2(MAX_TPB):0] core_block_size,
    output logic                                    kernel_done,
    output logic                                    aborted,
    output logic                                    config_error,
    output logic                                    busy,
    output logic [TC_WIDTH:0]                       blocks_completed,
    output logic [CYC_WIDTH-1:0]                    cycle_count
);

    localparam int LW = $clog2(MAX_TPB);
    localparam int SW = LW + 1;
    localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int BW = TC_WIDTH + 1;

    state_t               state, state_nxt;
    logic [TC_WIDTH-1:0]  tc_r;
    logic [SW-1:0]        log2_r;
    logic [BW-1:0]        next_block, total_c;
    logic [SW-1:0]        bs_s, rem_s, last_c;
    logic [IW-1:0]        rr_ptr, pick_idx;
    logic [NUM_CORES-1:0] active, eligible, done_hit, start_vec;
    logic                 pick_found, bad_cfg, accept, dispatch;

    function automatic logic [BW-1:0] popcnt(input logic [NUM_CORES-1:0] v);
        logic [BW-1:0] n;
        n = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            n = n + BW'(v[k]);
        end
        return n;
    endfunction

    // Block geometry follows directly from the latched launch fields, so it is stable all kernel.
    assign bs_s    = SW'(1) << log2_r;
    assign rem_s   = tc_r[SW-1:0] & (bs_s - SW'(1));
    assign last_c  = (rem_s == '0) ? bs_s : rem_s;
    assign total_c = ({1'b0, tc_r} + BW'(bs_s) - BW'(1)) >> log2_r;

    assign bad_cfg   = launch_tpb_log2 > SW'(LW);
    assign accept    = (state == IDLE) && launch_valid && launch_ready;
    assign eligible  = ~active & core_enable_mask;
    assign done_hit  = core_done & active;
    assign dispatch  = ((state == SETUP) || (state == RUN)) && !abort && pick_found
                       && (next_block < total_c);
    assign start_vec = dispatch ? (NUM_CORES'(1) << pick_idx) : '0;

    rr_pick #(
        .N (NUM_CORES),
        .IW(IW)
    ) u_pick (
        .eligible(eligible),
        .ptr     (rr_ptr),
        .found   (pick_found),
        .index   (pick_idx)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && !bad_cfg) state_nxt = SETUP;
            SETUP:   state_nxt = abort ? ABORT : ((total_c == '0) ? DONE : RUN);
            RUN: begin
                if (abort) state_nxt = ABORT;
                else if (next_block == total_c && active == '0) state_nxt = DONE;
            end
            DONE:    state_nxt = abort ? ABORT : IDLE;
            ABORT:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            launch_ready     <= 1'b1;
            busy             <= 1'b0;
            core_reset       <= '1;
            kernel_done      <= 1'b0;
            aborted          <= 1'b0;
            config_error     <= 1'b0;
            core_start       <= '0;
            core_block_id    <= '0;
            core_block_size  <= '0;
            blocks_completed <= '0;
            cycle_count      <= '0;
            tc_r             <= '0;
            log2_r           <= '0;
            next_block       <= '0;
            rr_ptr           <= '0;
            active           <= '0;
        end else begin
            state        <= state_nxt;
            launch_ready <= (state_nxt == IDLE);
            busy         <= (state_nxt != IDLE);
            core_reset   <= (state_nxt == IDLE || state_nxt == ABORT) ? '1 : '0;
            kernel_done  <= (state_nxt == DONE);
            aborted      <= (state_nxt == ABORT);
            config_error <= accept && bad_cfg;
            core_start   <= start_vec;

            if (state inside {SETUP, RUN, DONE}) begin
                cycle_count <= cycle_count + CYC_WIDTH'(1);
            end

            if (accept && !bad_cfg) begin
                tc_r             <= launch_thread_count;
                log2_r           <= launch_tpb_log2;
                next_block       <= '0;
                rr_ptr           <= '0;
                active           <= '0;
                blocks_completed <= '0;
                cycle_count      <= '0;
            end else if (state_nxt == ABORT) begin
                active <= '0;
            end else begin
                // A core freed here only becomes eligible next cycle, since pick uses registered active.
                active           <= (active & ~done_hit) | start_vec;
                blocks_completed <= blocks_completed + popcnt(done_hit);
                if (dispatch) begin
                    core_block_id[pick_idx]   <= next_block[TC_WIDTH-1:0];
                    core_block_size[pick_idx] <= (next_block == total_c - BW'(1)) ? last_c : bs_s;
                    next_block                <= next_block + BW'(1);
                    rr_ptr                    <= (int'(pick_idx) == NUM_CORES - 1) ? '0 : pick_idx + IW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_block_dispatcher.sv
// Directed bench for block_dispatcher: launch vector table plus hand-written abort/reset sequences.
module tb_block_dispatcher;
    import dispatch_pkg::*;

    localparam int NC = 4;
    localparam int TW = 16;
    localparam int MT = 8;
    localparam int CW = 32;
    localparam int SW = DEF_TPB_LOG2_W;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     launch_valid = 1'b0;
    logic                     launch_ready;
    logic [TW-1:0]            launch_thread_count = '0;
    logic [SW-1:0]            launch_tpb_log2 = '0;
    logic [NC-1:0]            core_enable_mask = '1;
    logic                     abort = 1'b0;
    logic [NC-1:0]            core_done = '0;
    logic [NC-1:0]            core_start;
    logic [NC-1:0]            core_reset;
    logic [NC-1:0][TW-1:0]    core_block_id;
    logic [NC-1:0][SW-1:0]    core_block_size;
    logic                     kernel_done, aborted, config_error, busy;
    logic [TW:0]              blocks_completed;
    logic [CW-1:0]            cycle_count;

    always #5 clk = ~clk;

    block_dispatcher #(
        .NUM_CORES(NC), .TC_WIDTH(TW), .MAX_TPB(MT), .CYC_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .launch_valid(launch_valid), .launch_ready(launch_ready),
        .launch_thread_count(launch_thread_count), .launch_tpb_log2(launch_tpb_log2),
        .core_enable_mask(core_enable_mask), .abort(abort), .core_done(core_done),
        .core_start(core_start), .core_reset(core_reset),
        .core_block_id(core_block_id), .core_block_size(core_block_size),
        .kernel_done(kernel_done), .aborted(aborted), .config_error(config_error),
        .busy(busy), .blocks_completed(blocks_completed), .cycle_count(cycle_count)
    );

    typedef struct {
        logic [TW-1:0] tc;
        logic [SW-1:0] l2;
        logic [NC-1:0] mask;
        int            dly;
        bit            err;
        int            blocks;
        int            last;
        bit            alt;
    } vec_t;

    typedef struct {
        int n_start;
        int first_lat;
        int kd_cnt;
        int kd_lat;
        int ce_cnt;
        int ce_lat;
        int ab_cnt;
        int bad_id;
        int bad_size;
        int bad_core;
        int repeats;
        int busy_cyc;
        bit timeout;
    } res_t;

    vec_t vecs[10];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Launches one kernel and plays the cores: each core pulses done dly negedges after its start.
    task automatic run_launch(input vec_t v, output res_t r);
        int            timer[NC];
        int            last_core;
        int            cyc;
        bit            stop;
        logic [SW-1:0] bs;
        logic [SW-1:0] exp_sz;
        r = '{default: 0};
        r.first_lat = -1;
        r.kd_lat = -1;
        r.ce_lat = -1;
        bs = SW'(1) << v.l2;
        last_core = -1;
        for (int k = 0; k < NC; k++) timer[k] = 0;
        @(negedge clk);
        launch_thread_count = v.tc;
        launch_tpb_log2 = v.l2;
        core_enable_mask = v.mask;
        launch_valid = 1'b1;
        @(negedge clk);
        launch_valid = 1'b0;
        cyc = 1;
        stop = 1'b0;
        while (!stop && cyc < 20000) begin
            if (busy) r.busy_cyc++;
            if (aborted) r.ab_cnt++;
            if (config_error) begin
                r.ce_cnt++;
                if (r.ce_lat < 0) r.ce_lat = cyc;
            end
            if (kernel_done) begin
                r.kd_cnt++;
                if (r.kd_lat < 0) r.kd_lat = cyc;
            end
            for (int k = 0; k < NC; k++) begin
                core_done[k] = 1'b0;
                if (timer[k] > 0) begin
                    timer[k]--;
                    if (timer[k] == 0) core_done[k] = 1'b1;
                end
            end
            for (int k = 0; k < NC; k++) begin
                if (core_start[k]) begin
                    exp_sz = (r.n_start == v.blocks - 1) ? SW'(v.last) : bs;
                    if (!v.mask[k]) r.bad_core++;
                    if (core_block_id[k] !== TW'(r.n_start)) r.bad_id++;
                    if (core_block_size[k] !== exp_sz) r.bad_size++;
                    if (k == last_core) r.repeats++;
                    if (r.first_lat < 0) r.first_lat = cyc;
                    last_core = k;
                    r.n_start++;
                    timer[k] = v.dly;
                end
            end
            if ((r.kd_cnt > 0 || r.ce_cnt > 0 || r.ab_cnt > 0) && launch_ready) begin
                stop = 1'b1;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        core_done = '0;
        r.timeout = !stop;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t r;
        int   kd;
        vecs[0] = '{16'd10,    4'd2,  4'hF, 2, 1'b0, 3,    2, 1'b0};
        vecs[1] = '{16'd0,     4'd1,  4'hF, 2, 1'b0, 0,    0, 1'b0};
        vecs[2] = '{16'd32,    4'd2,  4'h5, 3, 1'b0, 8,    4, 1'b1};
        vecs[3] = '{16'd1,     4'd0,  4'hF, 1, 1'b0, 1,    1, 1'b0};
        vecs[4] = '{16'd7,     4'd3,  4'hF, 1, 1'b0, 1,    7, 1'b0};
        vecs[5] = '{16'd17,    4'd3,  4'h8, 1, 1'b0, 3,    1, 1'b0};
        vecs[6] = '{16'd12,    4'd2,  4'h6, 1, 1'b0, 3,    4, 1'b1};
        vecs[7] = '{16'd5,     4'd4,  4'hF, 1, 1'b1, 0,    0, 1'b0};
        vecs[8] = '{16'd9,     4'd15, 4'hF, 1, 1'b1, 0,    0, 1'b0};
        vecs[9] = '{16'd65535, 4'd3,  4'hF, 1, 1'b0, 8192, 7, 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst.core_reset", core_reset, 4'hF);
        check("rst.launch_ready", launch_ready, 1);
        check("rst.busy", busy, 0);
        check("rst.core_start", core_start, 0);
        check("rst.cycle_count", cycle_count, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle.core_reset", core_reset, 4'hF);
        check("idle.blocks_completed", blocks_completed, 0);
        check("idle.kernel_done", kernel_done, 0);

        // Abort while idle is ignored
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("idle_abort.aborted", aborted, 0);
        check("idle_abort.launch_ready", launch_ready, 1);

        foreach (vecs[i]) begin
            run_launch(vecs[i], r);
            check($sformatf("v%0d.timeout", i), r.timeout, 0);
            if (vecs[i].err) begin
                check($sformatf("v%0d.config_error_cnt", i), r.ce_cnt, 1);
                check($sformatf("v%0d.config_error_lat", i), r.ce_lat, 1);
                check($sformatf("v%0d.busy_cycles", i), r.busy_cyc, 0);
                check($sformatf("v%0d.starts", i), r.n_start, 0);
                check($sformatf("v%0d.kernel_done_cnt", i), r.kd_cnt, 0);
            end else begin
                check($sformatf("v%0d.starts", i), r.n_start, vecs[i].blocks);
                check($sformatf("v%0d.bad_ids", i), r.bad_id, 0);
                check($sformatf("v%0d.bad_sizes", i), r.bad_size, 0);
                check($sformatf("v%0d.masked_core_starts", i), r.bad_core, 0);
                check($sformatf("v%0d.kernel_done_cnt", i), r.kd_cnt, 1);
                check($sformatf("v%0d.aborted_cnt", i), r.ab_cnt, 0);
                check($sformatf("v%0d.config_error_cnt", i), r.ce_cnt, 0);
                check($sformatf("v%0d.blocks_completed", i), blocks_completed, vecs[i].blocks);
                if (vecs[i].blocks > 0) begin
                    check($sformatf("v%0d.first_start_lat", i), r.first_lat, 2);
                end else begin
                    check($sformatf("v%0d.kernel_done_lat", i), r.kd_lat, 2);
                    check($sformatf("v%0d.cycle_count", i), cycle_count, 2);
                end
                if (vecs[i].alt) check($sformatf("v%0d.same_core_twice", i), r.repeats, 0);
            end
        end

        // Abort with two blocks in flight; core 2 would otherwise be dispatched on the abort edge
        @(negedge clk);
        launch_thread_count = 16'd16;
        launch_tpb_log2 = 4'd2;
        core_enable_mask = 4'b0111;
        launch_valid = 1'b1;
        @(negedge clk);
        launch_valid = 1'b0;
        check("ab.setup_core_reset", core_reset, 0);
        check("ab.setup_busy", busy, 1);
        @(negedge clk);
        check("ab.start0", core_start, 4'b0001);
        @(negedge clk);
        check("ab.start1", core_start, 4'b0010);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("ab.core_reset", core_reset, 4'hF);
        check("ab.aborted", aborted, 1);
        check("ab.kernel_done", kernel_done, 0);
        check("ab.no_dispatch", core_start, 0);
        check("ab.launch_ready_in_abort", launch_ready, 0);
        @(negedge clk);
        check("ab.launch_ready", launch_ready, 1);
        check("ab.aborted_cleared", aborted, 0);
        check("ab.busy", busy, 0);
        kd = 0;
        repeat (4) begin
            if (kernel_done) kd++;
            @(negedge clk);
        end
        check("ab.kernel_done_after", kd, 0);

        // core_done on core 0 in the cycle core 3 is dispatched, then reset mid-run
        core_enable_mask = 4'hF;
        launch_thread_count = 16'd64;
        launch_tpb_log2 = 4'd3;
        launch_valid = 1'b1;
        @(negedge clk);
        launch_valid = 1'b0;
        @(negedge clk);
        check("rr.start_c0", core_start, 4'b0001);
        @(negedge clk);
        check("rr.start_c1", core_start, 4'b0010);
        @(negedge clk);
        check("rr.start_c2", core_start, 4'b0100);
        core_done = 4'b0001;
        @(negedge clk);
        core_done = 4'b0000;
        check("rr.start_c3", core_start, 4'b1000);
        check("rr.id_c3", core_block_id[3], 3);
        @(negedge clk);
        check("rr.restart_c0", core_start, 4'b0001);
        check("rr.id_c0", core_block_id[0], 4);
        check("rr.size_c0", core_block_size[0], 8);
        check("rr.blocks_completed", blocks_completed, 1);
        #2 rst = 1'b1;
        #1;
        check("arst.core_start", core_start, 0);
        check("arst.core_reset", core_reset, 4'hF);
        check("arst.core_block_id", core_block_id, 0);
        check("arst.core_block_size", core_block_size, 0);
        check("arst.busy", busy, 0);
        check("arst.launch_ready", launch_ready, 1);
        check("arst.blocks_completed", blocks_completed, 0);
        check("arst.cycle_count", cycle_count, 0);
        @(negedge clk);
        rst = 1'b0;
        kd = 0;
        repeat (3) begin
            @(negedge clk);
            if (kernel_done || aborted) kd++;
        end
        check("arst.silent_discard", kd, 0);

        // Recovery after reset
        run_launch(vecs[0], r);
        check("post_rst.starts", r.n_start, 3);
        check("post_rst.kernel_done_cnt", r.kd_cnt, 1);
        check("post_rst.blocks_completed", blocks_completed, 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/block_dispatcher.md
Name: block_dispatcher

Overview:
Next-generation thread-block dispatcher. It sits between the host/launch controller and NUM_CORES compute cores.
- Accepts a kernel launch via valid/ready handshake.
- Splits the thread count into power-of-two-sized blocks and issues at most one block per cycle round-robin to idle, enabled cores.
- Tracks completion and reports kernel_done or aborted.
- Adds over the previous dispatcher: runtime block size, core enable mask, abort, and completion/cycle counters.

Parameters:
NUM_CORES, 4, number of cores served
TC_WIDTH, 16, width of thread count and block id
MAX_TPB, 8, maximum threads per block (power of two)
CYC_WIDTH, 32, width of kernel cycle counter

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
launch_valid  in  1  launch request
launch_ready  out  1  high only in IDLE
launch_thread_count  in  TC_WIDTH  total threads
launch_tpb_log2  in  $clog2(MAX_TPB)+1  block size = 1<<value
core_enable_mask  in  NUM_CORES  cores eligible for new blocks
abort  in  1  cancel the running kernel
core_done  in  NUM_CORES  1-cycle pulse per finished block
core_start  out  NUM_CORES  1-cycle start pulse per core
core_reset  out  NUM_CORES  active-high reset to cores
core_block_id  out  NUM_CORES x TC_WIDTH  block id per core
core_block_size  out  NUM_CORES x ($clog2(MAX_TPB)+1)  threads in block
kernel_done  out  1  1-cycle pulse on completion
aborted  out  1  1-cycle pulse on abort
config_error  out  1  1-cycle pulse on invalid launch
busy  out  1  high in any state other than IDLE
blocks_completed  out  TC_WIDTH+1  blocks retired in current/last kernel
cycle_count  out  CYC_WIDTH  cycles from SETUP to DONE, last kernel

Behaviour:
Reset:
- State IDLE; all pulses, core_start, ids, sizes and counters are 0.
- core_reset is all ones.
- Async assertion; a reset mid-kernel discards the kernel silently (no kernel_done or aborted pulse).

States: IDLE, SETUP, RUN, DONE, ABORT.

IDLE:
- launch_ready=1 and core_reset all ones.
- A launch is accepted on launch_valid&&launch_ready.
- If launch_tpb_log2 > log2(MAX_TPB): config_error pulses next cycle; stay IDLE.
- Otherwise: latch the launch fields, clear the counters, go to SETUP.

SETUP (1 cycle):
- total_blocks = (tc + bs - 1) >> log2, computed at TC_WIDTH+1 bits; no overflow.
- last_size = tc & (bs-1), or bs if that is 0.
- next_block=0; rr_ptr=0; core_reset cleared to 0.
- If total_blocks==0, go to DONE; otherwise go to RUN.

RUN:
- candidate = first core i, searching from rr_ptr upward with wrap, such that !active[i] && core_enable_mask[i].
- If a candidate exists and next_block<total_blocks, in the same edge:
  - core_start[i] pulses.
  - core_block_id[i]=next_block.
  - core_block_size[i] = last_size if next_block==total_blocks-1, else bs.
  - active[i] set; next_block increments; rr_ptr=i+1 mod NUM_CORES.
- Only one dispatch per cycle.
- core_done[i] while active[i]: clears active[i] and increments blocks_completed.
  - The freed core is eligible from the following cycle, never on the same edge.
- core_done on an inactive core is ignored.
- Clearing a mask bit stops new issue to that core only; an in-flight block still completes.
- An all-zero mask stalls indefinitely; there is no timeout.
- Exit condition, evaluated on registered values: next_block==total_blocks && active==0 -> DONE.

DONE (1 cycle): kernel_done pulses; go to IDLE.

abort in SETUP/RUN/DONE:
- Go to ABORT; abort takes priority over DONE and over dispatch in the same cycle.
- In ABORT (1 cycle): core_reset all ones, active cleared, aborted pulses, then IDLE.
- abort in IDLE is ignored.

Counters:
- cycle_count increments every cycle in SETUP/RUN/DONE and holds its value in IDLE.
- core_block_id and core_block_size hold their values after dispatch until the next dispatch to that core.

Latency: accept at cycle N -> SETUP at N+1 -> first core_start at N+2.

Decomposition:
- dispatch_pkg: state enum (IDLE, SETUP, RUN, DONE, ABORT); localparams for the TPB_LOG2 and size widths.
- One sub-module, rr_pick: combinational first-set search from a pointer with wrap. Inputs: eligible vector, pointer. Outputs: found, index.

Test Plan:
1. NUM_CORES=4, MAX_TPB=8, tc=10, log2=2.
   - Ids 0/1/2 go to cores 0/1/2 with sizes 4/4/2 on three consecutive cycles.
   - After all core_done pulses: one kernel_done pulse, blocks_completed=3.
2. tc=0, log2=1: no core_start; kernel_done pulses at N+2; blocks_completed=0.
3. mask=4'b0101, tc=32, log2=2, cores respond 3 cycles after start.
   - 8 blocks issue on cores 0 and 2 only, alternating; cores 1 and 3 never start.
4. abort while 2 blocks are active:
   - core_reset all ones for 1 cycle, aborted pulses, no kernel_done.
   - launch_ready returns the next cycle.
5. log2=4 with MAX_TPB=8: config_error pulses, busy stays 0, no core_start.
6. core_done on core 0 in the same cycle the last free core 3 is dispatched:
   - Core 0 is re-dispatched no earlier than the next cycle.
   - rst asserted mid-RUN: all outputs are at reset values immediately.
